usb_bit_stuffer: RTL and testbench
==================================

# usb_bit_stuffer

Serial USB bit stuffer that sits directly downstream of the CRC5 calculator in the transmit path. It consumes the CRC stage's serial packet stream (`out_bit` / `crc_valid_out`) and inserts a 0 after every run of six consecutive 1s. It back-pressures the CRC stage through `bs_ready` while a stuffed bit is emitted, and it feeds the NRZI encoder that follows.

## Interface
- `MAX_RUN`, default 6: number of consecutive accepted 1s that triggers a stuffed 0.
- `STATS_W`, default 8: width of the stuff-statistics counter (present only with the macro).

- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_bit`, input, 1: serial data bit from the CRC stage.
- `in_valid`, input, 1: `in_bit` is valid. High for the whole packet, low between packets.
- `bs_ready`, output, 1: stuffer accepts `in_bit` this cycle. Moore output.
- `out_bit`, output, 1: registered serial output bit to the NRZI stage.
- `out_valid`, output, 1: registered qualifier for `out_bit`.
- `out_done`, output, 1: one-cycle pulse marking end of packet.
- `stuff_count`, output, `STATS_W`: stuffed bits in the current or last packet (only with `USB_BS_STATS_EN`).

## Operation
- **Accept rule:** a bit is accepted in any cycle where `in_valid && bs_ready`. While `bs_ready` is low, upstream holds `in_bit` stable.
- **Run counter:** `ones_cnt`, 3 bits.
  - An accepted 0 clears it.
  - An accepted 1 increments it.
  - An accept from IDLE first reloads it to 0, then applies the bit.
- **States** (`bs_state_t`):
  - IDLE: `bs_ready`=1.
    - `in_valid` → accept, go to SEND.
    - If that bit is a 1 and `MAX_RUN`==1 → STUFF.
  - SEND: `bs_ready`=1.
    - `in_valid` → accept. If the accepted bit is 1 and `ones_cnt`==`MAX_RUN`-1 → STUFF, else stay in SEND.
    - `!in_valid` → IDLE, and `out_done` is asserted next cycle.
  - STUFF: `bs_ready`=0, nothing is accepted, `ones_cnt` is cleared, unconditionally go to SEND.
- **Trailing stuff:** a packet ending on the `MAX_RUN`-th 1 still gets its stuffed 0. STUFF runs regardless of `in_valid`, then SEND sees `!in_valid` and goes to IDLE.
- **Output register, next value:**
  - accept → `{out_valid,out_bit}` = `{1,in_bit}`
  - else in STUFF → `{1,0}`
  - else → `{0,0}`
- **`out_done`:** registered; equals 1 in the cycle after a SEND→IDLE transition.
- **`in_valid` low in STUFF:** legal, with no effect on that cycle.
- **`in_valid` low for one cycle inside SEND:** treated as end of packet; packets are contiguous.

## Timing
- Reset values: IDLE, `ones_cnt`=0; `out_bit`=0, `out_valid`=0, `out_done`=0, `stuff_count`=0. `bs_ready`=1 while in reset (IDLE).
- Reset mid-packet: all outputs go to reset values immediately (asynchronous). No partial stuff is emitted after release.
- Latency: a bit accepted at edge N appears on `out_bit` from edge N until edge N+1.
- When the sixth 1 is accepted at edge N:
  - `bs_ready`=0 during cycle N..N+1.
  - The stuffed 0 is visible after edge N+1.
  - The next data bit is accepted at edge N+2.
- Exactly one `bs_ready`-low cycle per stuffed bit. Throughput is one output bit per clock.
- `out_done` is high during the first cycle in which `out_valid` is 0 after the packet.

## Configuration
- Macro `USB_BS_STATS_EN`.
- **Defined:**
  - The `stuff_count` port and its counter exist.
  - The counter clears on an accept from IDLE and increments on each cycle in STUFF.
  - It saturates at 2^`STATS_W`-1 and holds its value through IDLE.
- **Undefined:** the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `usb_pkg` holds:
  - `bs_state_t`, the enum {IDLE, SEND, STUFF};
  - `USB_STUFF_RUN` = 6, the default for `MAX_RUN`.
- One sub-module, `bs_run_counter`, holds `ones_cnt` and the clear/increment logic. It outputs `run_hit`, meaning the accepted bit is the `MAX_RUN`-th consecutive 1.
- Everything else (FSM, output register, stats counter) lives in `usb_bit_stuffer`.

## Test plan
- Packet of 8 zeros → `out_bit` = 00000000, `bs_ready` never low, `out_done` pulses one cycle after the last output bit, `stuff_count`=0.
- Input 1111111 0 → output 111111 0 1 0, `bs_ready` low exactly one cycle (the cycle after the 6th 1 is accepted), `stuff_count`=1.
- Input of 12 ones → output 111111 0 111111 0 (trailing stuff), then `out_done`; `stuff_count`=2.
- Input 111110 111111 → no stuff after the first five 1s, one stuff after the final six, 13 output bits total.
- `in_valid` held high with bit 1 during STUFF → that bit is not consumed; it appears as the first bit after the stuffed 0 and `ones_cnt` restarts at 1.
- Assert `reset` in the STUFF cycle → `out_valid`/`out_bit` go to 0 immediately and `bs_ready`=1. After release, a new packet 1 0 produces exactly 1 0.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB transmit-path types and constants.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STUFF = 2'd2
  } bs_state_t;

  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/bs_run_counter.sv
// Consecutive-ones run counter for the bit stuffer; flags the MAX_RUN-th accepted 1.
module bs_run_counter
  import usb_pkg::*;
#(
  parameter int MAX_RUN = USB_STUFF_RUN
) (
  input  logic clock,
  input  logic reset,
  input  logic accept,
  input  logic data_bit,
  input  logic reload,
  input  logic clear,
  output logic run_hit
);

  localparam logic [2:0] HIT_CNT = 3'(MAX_RUN - 1);

  logic [2:0] ones_cnt;
  logic [2:0] base_cnt;

  // A packet start counts from zero even if the previous packet ended mid-run.
  assign base_cnt = reload ? 3'd0 : ones_cnt;
  assign run_hit  = accept && data_bit && (base_cnt == HIT_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ones_cnt <= 3'd0;
    end else if (clear) begin
      ones_cnt <= 3'd0;
    end else if (accept) begin
      ones_cnt <= data_bit ? base_cnt + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/usb_bit_stuffer.sv
// Serial USB bit stuffer: inserts a 0 after MAX_RUN consecutive 1s, stalling upstream for it.
// Optional stuff statistics counter enabled by USB_BS_STATS_EN.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int MAX_RUN = USB_STUFF_RUN,
  parameter int STATS_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_bit,
  input  logic               in_valid,
  output logic               bs_ready,
  output logic               out_bit,
  output logic               out_valid,
`ifdef USB_BS_STATS_EN
  output logic [STATS_W-1:0] stuff_count,
`endif
  output logic               out_done
);

  bs_state_t state;
  logic      accept;
  logic      run_hit;

  assign accept = in_valid && bs_ready;

  bs_run_counter #(
    .MAX_RUN (MAX_RUN)
  ) u_run_counter (
    .clock    (clock),
    .reset    (reset),
    .accept   (accept),
    .data_bit (in_bit),
    .reload   (state == IDLE),
    .clear    (state == STUFF),
    .run_hit  (run_hit)
  );

  // bs_ready is registered alongside the state so it is a clean Moore output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bs_ready  <= 1'b1;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= run_hit ? STUFF : SEND;
            bs_ready <= !run_hit;
          end
        end
        SEND: begin
          if (in_valid) begin
            state    <= run_hit ? STUFF : SEND;
            bs_ready <= !run_hit;
          end else begin
            state    <= IDLE;
            bs_ready <= 1'b1;
            out_done <= 1'b1;
          end
        end
        STUFF: begin
          state    <= SEND;
          bs_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          bs_ready <= 1'b1;
        end
      endcase

      if (accept) begin
        out_valid <= 1'b1;
        out_bit   <= in_bit;
      end else if (state == STUFF) begin
        out_valid <= 1'b1;
        out_bit   <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        out_bit   <= 1'b0;
      end
    end
  end

`ifdef USB_BS_STATS_EN
  localparam logic [STATS_W-1:0] STATS_MAX = '1;

  // Cleared at packet start, held through IDLE so software can read the last packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stuff_count <= '0;
    end else if (accept && state == IDLE) begin
      stuff_count <= '0;
    end else if (state == STUFF && stuff_count != STATS_MAX) begin
      stuff_count <= stuff_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Directed bench for usb_bit_stuffer: packet streams, stall cycles, end-of-packet pulse, reset.
module tb_usb_bit_stuffer;

  logic clock = 1'b0;
  logic reset;
  logic in_bit;
  logic in_valid;
  logic bs_ready;
  logic out_bit;
  logic out_valid;
  logic out_done;
`ifdef USB_BS_STATS_EN
  logic [7:0] stuff_count;
`endif

  int checks = 0;
  int errors = 0;

  usb_bit_stuffer #(
    .MAX_RUN (6),
    .STATS_W (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .bs_ready    (bs_ready),
    .out_bit     (out_bit),
    .out_valid   (out_valid),
`ifdef USB_BS_STATS_EN
    .stuff_count (stuff_count),
`endif
    .out_done    (out_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one contiguous packet (first bit = pat[len-1]) honouring bs_ready,
  // collects the qualified output stream and watches for the end-of-packet pulse.
  // Entered and left at #1 after a rising edge with in_valid low.
  task automatic run_packet(input logic [31:0] pat, input int len,
                            output logic [31:0] stream, output int slen,
                            output int rlow, output int dones, output int done_ok);
    int   idx;
    int   budget;
    logic prev_v;
    logic rdy;
    idx = 0; budget = 0; prev_v = 1'b0;
    stream = '0; slen = 0; rlow = 0; dones = 0; done_ok = 0;
    while (budget < 60) begin
      if (idx < len) begin
        in_valid = 1'b1;
        in_bit   = pat[len-1-idx];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
      end
      rdy = bs_ready;
      if (!rdy) rlow++;
      @(posedge clock); #1;
      if (in_valid && rdy) idx++;
      if (out_valid) begin
        stream = {stream[30:0], out_bit};
        slen++;
      end
      if (out_done) begin
        dones++;
        if (prev_v && !out_valid) done_ok = 1;
      end
      prev_v = out_valid;
      budget++;
      if (idx >= len && dones > 0) break;
    end
    if (budget >= 60) check("packet_timeout", 32'(budget), 32'd0);
    in_valid = 1'b0;
    in_bit   = 1'b0;
    // A couple of idle cycles to catch a stretched or repeated done pulse.
    repeat (2) begin
      @(posedge clock); #1;
      if (out_done) dones++;
      if (out_valid) slen++;
      if (!bs_ready) rlow++;
    end
  endtask

  logic [31:0] stream;
  int          slen;
  int          rlow;
  int          dones;
  int          done_ok;
  int          wait_cnt;

  initial begin
    reset    = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bit",   32'(out_bit),   32'd0);
    check("rst_out_done",  32'(out_done),  32'd0);
    check("rst_bs_ready",  32'(bs_ready),  32'd1);
`ifdef USB_BS_STATS_EN
    check("rst_stuff_count", 32'(stuff_count), 32'd0);
`endif
    #10 reset = 1'b0;
    @(posedge clock); #1;

    // Eight zeros: no stuffing at all.
    run_packet(32'h00, 8, stream, slen, rlow, dones, done_ok);
    check("zeros_stream",  stream,      32'h0);
    check("zeros_len",     32'(slen),   32'd8);
    check("zeros_rlow",    32'(rlow),   32'd0);
    check("zeros_dones",   32'(dones),  32'd1);
    check("zeros_done_ok", 32'(done_ok), 32'd1);
`ifdef USB_BS_STATS_EN
    check("zeros_stuffs", 32'(stuff_count), 32'd0);
`endif

    // 1111111 0 -> 111111 0 1 0; the seventh 1 is held across the stall.
    run_packet(32'b11111110, 8, stream, slen, rlow, dones, done_ok);
    check("run7_stream",  stream,       32'b111111010);
    check("run7_len",     32'(slen),    32'd9);
    check("run7_rlow",    32'(rlow),    32'd1);
    check("run7_dones",   32'(dones),   32'd1);
    check("run7_done_ok", 32'(done_ok), 32'd1);
`ifdef USB_BS_STATS_EN
    check("run7_stuffs", 32'(stuff_count), 32'd1);
`endif

    // Twelve ones: second run must be counted from the held bit, and trailing stuff emitted.
    run_packet(32'hFFF, 12, stream, slen, rlow, dones, done_ok);
    check("run12_stream",  stream,       32'b11111101111110);
    check("run12_len",     32'(slen),    32'd14);
    check("run12_rlow",    32'(rlow),    32'd2);
    check("run12_dones",   32'(dones),   32'd1);
    check("run12_done_ok", 32'(done_ok), 32'd1);
`ifdef USB_BS_STATS_EN
    check("run12_stuffs", 32'(stuff_count), 32'd2);
`endif

    // 111110 111111: five ones do not stuff; final six stuff at the tail.
    run_packet(32'b111110111111, 12, stream, slen, rlow, dones, done_ok);
    check("run5_stream", stream,    32'b1111101111110);
    check("run5_len",    32'(slen), 32'd13);
    check("run5_rlow",   32'(rlow), 32'd1);
    check("run5_dones",  32'(dones), 32'd1);
`ifdef USB_BS_STATS_EN
    check("run5_stuffs", 32'(stuff_count), 32'd1);
`endif

    // Reset asserted during the STUFF cycle.
    in_valid = 1'b1;
    in_bit   = 1'b1;
    wait_cnt = 0;
    while (bs_ready && wait_cnt < 12) begin
      @(posedge clock); #1;
      wait_cnt++;
    end
    check("rstmid_reached_stuff", 32'(bs_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_out_bit",   32'(out_bit),   32'd0);
    check("rstmid_bs_ready",  32'(bs_ready),  32'd1);
`ifdef USB_BS_STATS_EN
    check("rstmid_stuffs", 32'(stuff_count), 32'd0);
`endif
    in_valid = 1'b0;
    in_bit   = 1'b0;
    #2 reset = 1'b0;
    @(posedge clock); #1;
    check("rstmid_no_partial", 32'(out_valid), 32'd0);
    run_packet(32'b10, 2, stream, slen, rlow, dones, done_ok);
    check("post_rst_stream", stream,    32'b10);
    check("post_rst_len",    32'(slen), 32'd2);
    check("post_rst_rlow",   32'(rlow), 32'd0);
    check("post_rst_dones",  32'(dones), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
